// File: rtl/data_mem_unit_if.sv
// ---------------------------------------------------------------------------
// data_mem_unit_if
//   Bundles the core-side memory controls and the data-RAM req/ack bus used by
//   data_mem_unit. Clock and reset stay outside as plain ports.
//
//   Core side : MemRead, MemWrite, Opcode, Address, WriteData -> unit
//               ReadData, Busy, Done, Error                    <- unit
//   RAM side  : ram_req, ram_we, ram_addr, ram_wdata, ram_be   <- unit
//               ram_rdata, ram_ack                             -> unit
//
//   modport slave  : the load/store unit's view
//   modport master : the environment's view (core plus data RAM)
// ---------------------------------------------------------------------------
interface data_mem_unit_if;
    logic        MemRead;
    logic        MemWrite;
    logic [5:0]  Opcode;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Busy;
    logic        Done;
    logic        Error;
    logic        ram_req;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_be;
    logic [31:0] ram_rdata;
    logic        ram_ack;

    modport slave (
        input  MemRead, MemWrite, Opcode, Address, WriteData, ram_rdata, ram_ack,
        output ReadData, Busy, Done, Error, ram_req, ram_we, ram_addr, ram_wdata, ram_be
    );

    modport master (
        output MemRead, MemWrite, Opcode, Address, WriteData, ram_rdata, ram_ack,
        input  ReadData, Busy, Done, Error, ram_req, ram_we, ram_addr, ram_wdata, ram_be
    );
endinterface

// File: rtl/data_mem_unit.sv
// ---------------------------------------------------------------------------
// data_mem_unit
//   Load/store stage behind the core. Accepts LW/LB/SW/SB requests, runs one
//   req/ack transaction on the data RAM, returns load data on ReadData.
//   Misaligned word accesses and illegal requests finish immediately with
//   Error and never touch the RAM.
//
//   Ports:
//     Clk    - clock, all state changes on posedge
//     Reset  - synchronous, active-high
//     bus    - data_mem_unit_if.slave (core controls + RAM req/ack bus)
//
//   Parameter:
//     TIMEOUT_CYCLES - REQ cycles without ram_ack before the request is aborted
//
//   Optional feature macro:
//     DMEM_TIMEOUT_EN - when defined, a stalled REQ aborts with Error after
//                       TIMEOUT_CYCLES cycles; otherwise REQ waits forever.
// ---------------------------------------------------------------------------
module data_mem_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input logic           Clk,
    input logic           Reset,
    data_mem_unit_if.slave bus
);
    localparam logic [5:0] OpLb = 6'b100000;
    localparam logic [5:0] OpLw = 6'b100011;
    localparam logic [5:0] OpSb = 6'b101000;
    localparam logic [5:0] OpSw = 6'b101011;

    if (TIMEOUT_CYCLES < 1) begin : gBadTimeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_t;
    state_t state;

    logic       reqByte;
    logic [1:0] reqLane;

    logic       isByte, isWord, illegal, misaligned;
    logic [3:0] laneMask;
    logic [7:0] laneByte;

    always_comb begin
        isByte     = (bus.Opcode == OpLb) || (bus.Opcode == OpSb);
        isWord     = (bus.Opcode == OpLw) || (bus.Opcode == OpSw);
        // Opcode must match the direction actually requested.
        illegal    = (bus.MemRead & bus.MemWrite)
                   | (bus.MemRead  & (bus.Opcode != OpLb) & (bus.Opcode != OpLw))
                   | (bus.MemWrite & (bus.Opcode != OpSb) & (bus.Opcode != OpSw));
        misaligned = isWord && (bus.Address[1:0] != 2'b00);
        laneMask   = 4'b0001 << bus.Address[1:0];
        case (reqLane)
            2'd0:    laneByte = bus.ram_rdata[7:0];
            2'd1:    laneByte = bus.ram_rdata[15:8];
            2'd2:    laneByte = bus.ram_rdata[23:16];
            default: laneByte = bus.ram_rdata[31:24];
        endcase
    end

`ifdef DMEM_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] timeoutCnt;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= StIdle;
            bus.ReadData  <= '0;
            bus.Busy      <= 1'b0;
            bus.Done      <= 1'b0;
            bus.Error     <= 1'b0;
            bus.ram_req   <= 1'b0;
            bus.ram_we    <= 1'b0;
            bus.ram_addr  <= '0;
            bus.ram_wdata <= '0;
            bus.ram_be    <= '0;
            reqByte       <= 1'b0;
            reqLane       <= '0;
`ifdef DMEM_TIMEOUT_EN
            timeoutCnt    <= '0;
`endif
        end else begin
            case (state)
                StIdle: begin
                    bus.Done  <= 1'b0;
                    bus.Error <= 1'b0;
                    if (bus.MemRead | bus.MemWrite) begin
                        bus.Busy <= 1'b1;
                        if (illegal || misaligned) begin
                            state     <= StDone;
                            bus.Done  <= 1'b1;
                            bus.Error <= 1'b1;
                        end else begin
                            state         <= StReq;
                            bus.ram_req   <= 1'b1;
                            bus.ram_we    <= bus.MemWrite;
                            bus.ram_addr  <= {bus.Address[31:2], 2'b00};
                            bus.ram_be    <= isByte ? laneMask : 4'b1111;
                            bus.ram_wdata <= isByte ? {4{bus.WriteData[7:0]}} : bus.WriteData;
                            reqByte       <= isByte;
                            reqLane       <= bus.Address[1:0];
                        end
                    end
                end
                StReq: begin
                    // Ack takes priority over an expiry on the same edge.
                    if (bus.ram_ack) begin
                        bus.ram_req <= 1'b0;
                        if (!bus.ram_we)
                            bus.ReadData <= reqByte ? {{24{laneByte[7]}}, laneByte} : bus.ram_rdata;
                        state    <= StDone;
                        bus.Done <= 1'b1;
`ifdef DMEM_TIMEOUT_EN
                        timeoutCnt <= '0;
                    end else if (timeoutCnt == CntW'(TIMEOUT_CYCLES - 1)) begin
                        bus.ram_req <= 1'b0;
                        state       <= StDone;
                        bus.Done    <= 1'b1;
                        bus.Error   <= 1'b1;
                        timeoutCnt  <= '0;
                    end else begin
                        timeoutCnt <= timeoutCnt + CntW'(1);
`endif
                    end
                end
                StDone: begin
                    state     <= StIdle;
                    bus.Done  <= 1'b0;
                    bus.Error <= 1'b0;
                    bus.Busy  <= 1'b0;
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_unit.sv
module tb_data_mem_unit;
    localparam logic [5:0] OpLb = 6'b100000;
    localparam logic [5:0] OpLw = 6'b100011;
    localparam logic [5:0] OpSb = 6'b101000;
    localparam logic [5:0] OpSw = 6'b101011;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    data_mem_unit_if bus();

    data_mem_unit #(.TIMEOUT_CYCLES(16)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int unsigned ackDelay;
        logic        expErr;
        logic        expAccess;
        logic        expWe;
        logic [3:0]  expBe;
        logic [31:0] expAddr;
        logic [31:0] expWdata;
        logic [31:0] expRead;
    } vec_t;

    vec_t vecs[12];
    vec_t sb[$];

    int unsigned checks = 0;
    int unsigned passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic checkAllZero(input string tag);
        chk({tag, " ReadData"}, bus.ReadData, 32'h0);
        chk({tag, " Busy"}, {31'b0, bus.Busy}, 32'h0);
        chk({tag, " Done"}, {31'b0, bus.Done}, 32'h0);
        chk({tag, " Error"}, {31'b0, bus.Error}, 32'h0);
        chk({tag, " ram_req"}, {31'b0, bus.ram_req}, 32'h0);
        chk({tag, " ram_we"}, {31'b0, bus.ram_we}, 32'h0);
        chk({tag, " ram_addr"}, bus.ram_addr, 32'h0);
        chk({tag, " ram_wdata"}, bus.ram_wdata, 32'h0);
        chk({tag, " ram_be"}, {28'b0, bus.ram_be}, 32'h0);
    endtask

    task automatic runVec(input vec_t v, input int idx);
        vec_t        e;
        int unsigned cyc, reqIdx, expLat;
        bit          sawReq, finished, unstable;
        logic [31:0] addr0;
        @(negedge Clk);
        bus.MemRead   = v.rd;
        bus.MemWrite  = v.wr;
        bus.Opcode    = v.op;
        bus.Address   = v.addr;
        bus.WriteData = v.wdata;
        sb.push_back(v);
        @(posedge Clk);
        #1;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        cyc = 0; reqIdx = 0; sawReq = 0; finished = 0; unstable = 0; addr0 = '0;
        while (!finished && cyc < 64) begin
            @(negedge Clk);
            cyc++;
            if (cyc == 1) chk($sformatf("v%0d Busy", idx), {31'b0, bus.Busy}, 32'h1);
            if (bus.ram_req) begin
                reqIdx++;
                if (!sawReq) begin
                    sawReq = 1;
                    addr0  = bus.ram_addr;
                    chk($sformatf("v%0d ram_addr", idx), bus.ram_addr, v.expAddr);
                    chk($sformatf("v%0d ram_we", idx), {31'b0, bus.ram_we}, {31'b0, v.expWe});
                    chk($sformatf("v%0d ram_be", idx), {28'b0, bus.ram_be}, {28'b0, v.expBe});
                    if (v.expWe) chk($sformatf("v%0d ram_wdata", idx), bus.ram_wdata, v.expWdata);
                end else if (bus.ram_addr !== addr0) unstable = 1;
                if (reqIdx > v.ackDelay) begin
                    bus.ram_ack   = 1'b1;
                    bus.ram_rdata = v.rdata;
                end else begin
                    bus.ram_ack   = 1'b0;
                    bus.ram_rdata = $urandom;
                end
            end else bus.ram_ack = 1'b0;
            if (bus.Done) begin
                finished = 1;
                if (sb.size() == 0) chk($sformatf("v%0d scoreboard empty", idx), 32'h0, 32'h1);
                else begin
                    e = sb.pop_front();
                    expLat = e.expAccess ? e.ackDelay + 2 : 1;
                    chk($sformatf("v%0d Error", idx), {31'b0, bus.Error}, {31'b0, e.expErr});
                    chk($sformatf("v%0d ReadData", idx), bus.ReadData, e.expRead);
                    chk($sformatf("v%0d accessed", idx), {31'b0, sawReq}, {31'b0, e.expAccess});
                    chk($sformatf("v%0d latency", idx), cyc, expLat);
                end
            end
        end
        if (!finished) chk($sformatf("v%0d Done within budget", idx), 32'h0, 32'h1);
        if (sawReq) chk($sformatf("v%0d ram_addr stable", idx), {31'b0, unstable}, 32'h0);
        @(negedge Clk);
        chk($sformatf("v%0d Done pulse ends", idx), {31'b0, bus.Done}, 32'h0);
        chk($sformatf("v%0d Busy clears", idx), {31'b0, bus.Busy}, 32'h0);
    endtask

    initial begin
        bit          sawDone, errAtDone;
        int unsigned reqHigh, busyCnt, doneCnt, cyc;
        logic [31:0] rdAtDone;

        //        rd wr op    addr          wdata         rdata         dly err acc we be       expAddr       expWdata      expRead
        vecs[0]  = '{1, 0, OpLw, 32'h00000010, 32'h0,        32'hDEADBEEF, 0, 0, 1, 0, 4'b1111, 32'h00000010, 32'h0,        32'hDEADBEEF};
        vecs[1]  = '{1, 0, OpLb, 32'h00000013, 32'h0,        32'h80FF1234, 0, 0, 1, 0, 4'b1000, 32'h00000010, 32'h0,        32'hFFFFFF80};
        vecs[2]  = '{1, 0, OpLb, 32'h00000011, 32'h0,        32'h80FF1234, 0, 0, 1, 0, 4'b0010, 32'h00000010, 32'h0,        32'h00000012};
        vecs[3]  = '{0, 1, OpSb, 32'h00000022, 32'h000000A5, 32'h0,        1, 0, 1, 1, 4'b0100, 32'h00000020, 32'hA5A5A5A5, 32'h00000012};
        vecs[4]  = '{1, 0, OpLw, 32'h00000006, 32'h0,        32'h0,        0, 1, 0, 0, 4'b0000, 32'h0,        32'h0,        32'h00000012};
        vecs[5]  = '{1, 1, OpLw, 32'h00000040, 32'h0,        32'h0,        0, 1, 0, 0, 4'b0000, 32'h0,        32'h0,        32'h00000012};
        vecs[6]  = '{1, 0, OpSw, 32'h00000040, 32'h0,        32'h0,        0, 1, 0, 0, 4'b0000, 32'h0,        32'h0,        32'h00000012};
        vecs[7]  = '{0, 1, OpSw, 32'h00000030, 32'h12345678, 32'h0,        2, 0, 1, 1, 4'b1111, 32'h00000030, 32'h12345678, 32'h00000012};
        vecs[8]  = '{0, 1, OpSw, 32'h00000031, 32'h12345678, 32'h0,        0, 1, 0, 0, 4'b0000, 32'h0,        32'h0,        32'h00000012};
        vecs[9]  = '{1, 0, OpLb, 32'h00000020, 32'h0,        32'h0000007F, 1, 0, 1, 0, 4'b0001, 32'h00000020, 32'h0,        32'h0000007F};
        vecs[10] = '{1, 0, OpLw, 32'h00000104, 32'h0,        32'hCAFEF00D, 5, 0, 1, 0, 4'b1111, 32'h00000104, 32'h0,        32'hCAFEF00D};
        vecs[11] = '{1, 0, OpLb, 32'h00000102, 32'h0,        32'h00AB0000, 0, 0, 1, 0, 4'b0100, 32'h00000100, 32'h0,        32'hFFFFFFAB};

        Reset = 1'b1;
        bus.MemRead = 1'b0; bus.MemWrite = 1'b0; bus.Opcode = '0;
        bus.Address = '0; bus.WriteData = '0; bus.ram_rdata = '0; bus.ram_ack = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        checkAllZero("reset");
        @(negedge Clk);
        Reset = 1'b0;

        for (int i = 0; i < 12; i++) runVec(vecs[i], i);

        // Request while busy is dropped; ack while idle is ignored.
        @(negedge Clk);
        bus.MemRead = 1'b1; bus.Opcode = OpLw; bus.Address = 32'h50;
        @(posedge Clk);
        #1;
        bus.MemRead = 1'b0;
        sawDone = 0; doneCnt = 0; cyc = 0;
        while (!sawDone && cyc < 32) begin
            @(negedge Clk);
            cyc++;
            if (cyc == 2) begin
                bus.MemWrite = 1'b1; bus.Opcode = OpSw; bus.Address = 32'h80;
            end else bus.MemWrite = 1'b0;
            bus.ram_ack   = (cyc == 4);
            bus.ram_rdata = 32'h11223344;
            if (bus.Done) sawDone = 1;
        end
        chk("busy done seen", {31'b0, sawDone}, 32'h1);
        chk("busy ReadData", bus.ReadData, 32'h11223344);
        chk("busy ram_addr kept", bus.ram_addr, 32'h50);
        chk("busy ram_we kept", {31'b0, bus.ram_we}, 32'h0);
        reqHigh = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge Clk);
            bus.ram_ack = 1'b1;
            if (bus.ram_req) reqHigh++;
            if (bus.Done) doneCnt++;
        end
        bus.ram_ack = 1'b0;
        chk("dropped req no access", reqHigh, 0);
        chk("idle ack no Done", doneCnt, 0);

        // Reset during REQ cycle 3; a late ack must be ignored.
        @(negedge Clk);
        bus.MemRead = 1'b1; bus.Opcode = OpLw; bus.Address = 32'h70;
        @(posedge Clk);
        #1;
        bus.MemRead = 1'b0;
        reqHigh = 0;
        while (reqHigh < 3 && cyc < 200) begin
            @(negedge Clk);
            cyc++;
            if (bus.ram_req) reqHigh++;
        end
        chk("pre-reset req cycles", reqHigh, 3);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        checkAllZero("midreset");
        @(negedge Clk);
        Reset = 1'b0;
        reqHigh = 0; doneCnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            bus.ram_ack = 1'b1; bus.ram_rdata = 32'h55AA55AA;
            if (bus.ram_req) reqHigh++;
            if (bus.Done) doneCnt++;
        end
        bus.ram_ack = 1'b0;
        chk("late ack no req", reqHigh, 0);
        chk("late ack no Done", doneCnt, 0);
        chk("late ack ReadData", bus.ReadData, 32'h0);

        // Ack never arrives.
        @(negedge Clk);
        bus.MemRead = 1'b1; bus.Opcode = OpLw; bus.Address = 32'h60;
        @(posedge Clk);
        #1;
        bus.MemRead = 1'b0;
        reqHigh = 0; busyCnt = 0; sawDone = 0; errAtDone = 0; rdAtDone = '0;
        for (int k = 0; k < 100; k++) begin
            @(negedge Clk);
            if (bus.ram_req) reqHigh++;
            if (bus.Busy) busyCnt++;
            if (bus.Done && !sawDone) begin
                sawDone = 1; errAtDone = bus.Error; rdAtDone = bus.ReadData;
            end
        end
`ifdef DMEM_TIMEOUT_EN
        chk("timeout req cycles", reqHigh, 16);
        chk("timeout Done", {31'b0, sawDone}, 32'h1);
        chk("timeout Error", {31'b0, errAtDone}, 32'h1);
        chk("timeout ReadData", rdAtDone, 32'h0);
`else
        chk("stall req cycles", reqHigh, 100);
        chk("stall Busy cycles", busyCnt, 100);
        chk("stall no Done", {31'b0, sawDone}, 32'h0);
`endif
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        chk("final ram_req", {31'b0, bus.ram_req}, 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
